// File: rtl/prio_writer_if.sv
// prio_writer_if: item stream in and page-memory write port out.
// master = the writer block, slave = the stream source / memory side.
interface prio_writer_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 36
);
   logic              din_valid;
   logic [DATA_W-1:0] din;
   logic              wr_en;
   logic [ADDR_W:0]   wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      input  din_valid,
      input  din,
      output wr_en,
      output wr_addr,
      output wr_data
   );

   modport slave (
      output din_valid,
      output din,
      input  wr_en,
      input  wr_addr,
      input  wr_data
   );
endinterface

// File: rtl/prio_writer.sv
// prio_writer: ping-pong page writer feeding the priority-encoder reader.
// Define PRIO_WR_DROP_CNT_EN to add the drop_count output.
module prio_writer #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 36
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   prio_writer_if.master     bus,
   output logic [ADDR_W-1:0] item_count,
   output logic              rd_page,
   output logic              count_valid,
   output logic              overflow
`ifdef PRIO_WR_DROP_CNT_EN
   ,
   output logic [7:0]        drop_count
`endif
);

   typedef enum logic {IDLE, FILL} state_t;

   localparam logic [ADDR_W-1:0] CNT_MAX = '1;

   state_t            state, state_nxt;
   logic              page;
   logic [ADDR_W-1:0] cnt;
   logic              dropped;

   logic              open_x;
   logic              close_x;
   logic              wpage;
   logic [ADDR_W-1:0] wcnt;
   logic              accept;
   logic              drop;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // An init always starts a fresh crossing, so any item on the same
   // cycle lands at address 0 of the page that becomes active.
   always_comb begin
      state_nxt = state;
      open_x    = 1'b0;
      close_x   = 1'b0;
      unique case (state)
         IDLE: begin
            if (init) begin
               state_nxt = FILL;
               open_x    = 1'b1;
            end
         end
         FILL: begin
            if (init) begin
               open_x  = 1'b1;
               close_x = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      wpage  = close_x ? ~page : page;
      wcnt   = open_x ? '0 : cnt;
      accept = bus.din_valid && (state == FILL || open_x)
               && (wcnt != CNT_MAX);
      drop   = bus.din_valid && (state == FILL) && !open_x
               && (cnt == CNT_MAX);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         item_count  <= '0;
         rd_page     <= 1'b1;
         count_valid <= 1'b0;
         overflow    <= 1'b0;
         page        <= 1'b0;
         cnt         <= '0;
         dropped     <= 1'b0;
      end else begin
         bus.wr_en <= accept;
         if (accept) begin
            bus.wr_addr <= {wpage, wcnt};
            bus.wr_data <= bus.din;
         end
         cnt     <= accept ? wcnt + 1'b1 : wcnt;
         page    <= wpage;
         dropped <= (dropped & ~open_x) | drop;
         if (close_x) begin
            item_count  <= cnt;
            rd_page     <= page;
            count_valid <= 1'b1;
            overflow    <= dropped;
         end
      end
   end

`ifdef PRIO_WR_DROP_CNT_EN
   logic [7:0] dcnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         dcnt       <= '0;
         drop_count <= '0;
      end else begin
         if (close_x) drop_count <= dcnt;
         if (open_x)
            dcnt <= '0;
         else if (drop && dcnt != 8'hFF)
            dcnt <= dcnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_prio_writer.sv
// tb_prio_writer: directed + randomized check of prio_writer against a
// crossing-level model (queue of accepted items per page).
module tb_prio_writer;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 36;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              init;
   logic [ADDR_W-1:0] item_count;
   logic              rd_page;
   logic              count_valid;
   logic              overflow;
`ifdef PRIO_WR_DROP_CNT_EN
   logic [7:0]        drop_count;
`endif

   prio_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   prio_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .init       (init),
      .bus        (bus),
      .item_count (item_count),
      .rd_page    (rd_page),
      .count_valid(count_valid),
      .overflow   (overflow)
`ifdef PRIO_WR_DROP_CNT_EN
      ,
      .drop_count (drop_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Model state: one crossing is a queue of accepted items.
   logic              m_live = 1'b0;
   logic              m_open;
   logic              m_page;
   logic [DATA_W-1:0] m_items[$];
   int                m_drops;
   logic              e_wr_en;
   logic [ADDR_W:0]   e_addr;
   logic [DATA_W-1:0] e_data;
   int                e_cnt;
   logic              e_rdp;
   logic              e_cv;
   logic              e_ovf;
   int                e_dc;

   always @(posedge clk) begin
      if (reset) begin
         m_open  = 1'b0;
         m_page  = 1'b0;
         m_items.delete();
         m_drops = 0;
         e_wr_en = 1'b0;
         e_addr  = '0;
         e_data  = '0;
         e_cnt   = 0;
         e_rdp   = 1'b1;
         e_cv    = 1'b0;
         e_ovf   = 1'b0;
         e_dc    = 0;
         m_live  = 1'b1;
      end else if (m_live) begin
         e_wr_en = 1'b0;
         if (init) begin
            if (m_open) begin
               e_cnt  = m_items.size();
               e_ovf  = (m_drops > 0);
               e_rdp  = m_page;
               e_cv   = 1'b1;
               e_dc   = (m_drops > 255) ? 255 : m_drops;
               m_page = ~m_page;
            end
            m_open  = 1'b1;
            m_drops = 0;
            m_items.delete();
         end
         if (bus.din_valid && m_open) begin
            if (m_items.size() < DEPTH - 1) begin
               e_wr_en = 1'b1;
               e_addr  = {m_page, ADDR_W'(m_items.size())};
               e_data  = bus.din;
               m_items.push_back(bus.din);
            end else begin
               m_drops++;
            end
         end
      end
      #1;
      if (m_live) begin
         chk("wr_en", 64'(bus.wr_en), 64'(e_wr_en));
         chk("wr_addr", 64'(bus.wr_addr), 64'(e_addr));
         chk("wr_data", 64'(bus.wr_data), 64'(e_data));
         chk("item_count", 64'(item_count), 64'(e_cnt));
         chk("rd_page", 64'(rd_page), 64'(e_rdp));
         chk("count_valid", 64'(count_valid), 64'(e_cv));
         chk("overflow", 64'(overflow), 64'(e_ovf));
`ifdef PRIO_WR_DROP_CNT_EN
         chk("drop_count", 64'(drop_count), 64'(e_dc));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic r, input logic i, input logic v);
      reset         = r;
      init          = i;
      bus.din_valid = v;
      bus.din       = DATA_W'({$urandom(), $urandom()});
   endtask

   int nw;
   logic [ADDR_W:0] last_a;
   int lim[4];

   initial begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
      tick();
      chk("rst_rd_page", 64'(rd_page), 64'd1);
      chk("rst_cv", 64'(count_valid), 64'd0);
      chk("rst_count", 64'(item_count), 64'd0);
      chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);

      // data before the first init is ignored
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b1);
         tick();
         chk("idle_wr_en", 64'(bus.wr_en), 64'd0);
      end
      chk("idle_cv", 64'(count_valid), 64'd0);
      chk("idle_rd_page", 64'(rd_page), 64'd1);

      drive(1'b0, 1'b1, 1'b0);
      tick();
      chk("open_cv", 64'(count_valid), 64'd0);
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, 1'b1);
         tick();
         chk("five_wr_en", 64'(bus.wr_en), 64'd1);
         chk("five_addr", 64'(bus.wr_addr), 64'(k));
      end
      drive(1'b0, 1'b1, 1'b0);
      tick();
      chk("five_count", 64'(item_count), 64'd5);
      chk("five_rd_page", 64'(rd_page), 64'd0);
      chk("five_cv", 64'(count_valid), 64'd1);
      chk("five_ovf", 64'(overflow), 64'd0);
      drive(1'b0, 1'b0, 1'b1);
      tick();
      chk("page1_addr", 64'(bus.wr_addr), 64'h40);

      // 70 items into one crossing: 63 written, 7 dropped
      drive(1'b0, 1'b1, 1'b0);
      tick();
      chk("one_count", 64'(item_count), 64'd1);
      nw = 0;
      last_a = '0;
      for (int k = 0; k < 70; k++) begin
         drive(1'b0, 1'b0, 1'b1);
         tick();
         if (bus.wr_en) begin
            nw++;
            last_a = bus.wr_addr;
         end
      end
      drive(1'b0, 1'b0, 1'b0);
      tick();
      chk("full_writes", 64'(nw), 64'd63);
      chk("full_last_addr", 64'(last_a), 64'h3E);
      drive(1'b0, 1'b1, 1'b0);
      tick();
      chk("full_count", 64'(item_count), 64'd63);
      chk("full_ovf", 64'(overflow), 64'd1);
`ifdef PRIO_WR_DROP_CNT_EN
      chk("full_drop_count", 64'(drop_count), 64'd7);
`endif

      // item coincident with init belongs to the new crossing
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b1);
         tick();
      end
      drive(1'b0, 1'b1, 1'b1);
      tick();
      chk("coin_count", 64'(item_count), 64'd3);
      chk("coin_ovf", 64'(overflow), 64'd0);
      chk("coin_wr_en", 64'(bus.wr_en), 64'd1);
      chk("coin_addr", 64'(bus.wr_addr), 64'h00);
      drive(1'b0, 1'b1, 1'b0);
      tick();
      chk("coin_next_count", 64'(item_count), 64'd1);

      // back-to-back init with no data
      drive(1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("b2b_count", 64'(item_count), 64'd0);
         chk("b2b_ovf", 64'(overflow), 64'd0);
         chk("b2b_rd_page", 64'(rd_page), 64'(k % 2));
      end

      // reset mid-crossing, coincident with an item
      drive(1'b0, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b0, 1'b1);
         tick();
      end
      drive(1'b1, 1'b0, 1'b1);
      tick();
      chk("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
      chk("mid_rst_addr", 64'(bus.wr_addr), 64'd0);
      chk("mid_rst_data", 64'(bus.wr_data), 64'd0);
      chk("mid_rst_rd_page", 64'(rd_page), 64'd1);
      chk("mid_rst_cv", 64'(count_valid), 64'd0);
      drive(1'b0, 1'b1, 1'b1);
      tick();
      chk("restart_wr_en", 64'(bus.wr_en), 64'd1);
      chk("restart_addr", 64'(bus.wr_addr), 64'd0);

      // randomized phases with growing crossing length
      lim[0] = 3;
      lim[1] = 30;
      lim[2] = 150;
      lim[3] = 400;
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < 1000; c++) begin
            drive($urandom_range(0, 599) == 0,
                  $urandom_range(0, lim[ph]) == 0,
                  $urandom_range(0, 3) != 0);
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/prio_writer.md
Name: prio_writer

Overview:
- Write-side companion of the priority-encoder readout logic.
- Accepts a stream of data items during one crossing and writes them into a ping-pong memory at sequential addresses.
- At each `init` it swaps pages and hands the reader the finished page number and its item count, which the reader uses as its initial count.
- While the reader drains one page, this block fills the other.

Parameters:
- ADDR_W, 6, low address bits per page; page depth is 2^ADDR_W.
- DATA_W, 36, item width in bits.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- init  input  1  one-cycle crossing boundary strobe; swaps pages.
- din_valid  input  1  item present on din this cycle.
- din  input  DATA_W  item data.
- wr_en  output  1  memory write strobe (registered).
- wr_addr  output  ADDR_W+1  {page bit, low address} (registered).
- wr_data  output  DATA_W  memory write data (registered).
- item_count  output  ADDR_W  number of items in the completed page; drives the reader's initial count.
- rd_page  output  1  page the reader must use (complement of the write page).
- count_valid  output  1  item_count/rd_page refer to a real completed crossing.
- overflow  output  1  the completed crossing dropped at least one item.

Behaviour:
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, item_count=0.
  - rd_page=1, count_valid=0, overflow=0.
  - Internal: write page=0, write counter=0, sticky drop flag=0, state=IDLE.
- States:
  - IDLE: din_valid is ignored and nothing is written. On init, go to FILL: write page stays 0, counter is cleared, count_valid stays 0. The first init only opens the first crossing.
  - FILL: items are accepted. On init, the current crossing closes and a new one opens.
- Accept rule in FILL:
  - If din_valid=1 and counter < 2^ADDR_W-1, the item is accepted.
  - Next cycle: wr_en=1, wr_addr={page, counter}, wr_data=din. Counter increments.
  - Write latency is exactly 1 cycle from din to wr_*.
- Full: counter saturates at 2^ADDR_W-1 (63 at default), matching the reader's 6-bit count.
  - Further din_valid is dropped with no write, and the sticky drop flag is set.
  - The top address (63) is never written.
- init in FILL, cycle t. These outputs change at t+1:
  - item_count = counter value including any item accepted at t-1; overflow = drop flag.
  - rd_page = old write page; count_valid=1.
  - Write page toggles, counter clears to 0, drop flag clears.
- Simultaneous init and din_valid in FILL: the item belongs to the NEW crossing.
  - It is written at {new page, 0}.
  - The new counter is 1 after the cycle.
  - It is not counted in the item_count being reported.
- Simultaneous init and din_valid in IDLE: the item is accepted as item 0 of page 0.
- Back-to-back init, with no items between: report item_count=0, overflow=0, and toggle the page every time.
- wr_en is high only in the cycle after an accepted item; wr_addr/wr_data hold their last value otherwise.
- Reset mid-crossing:
  - All state returns to reset values at the next edge and any pending write is cancelled (wr_en=0).
  - Reset has priority over init and din_valid in the same cycle.
- item_count, rd_page, overflow and count_valid are stable between init strobes.

Optional Feature:
- PRIO_WR_DROP_CNT_EN: adds output drop_count [7:0].
  - With the macro defined:
    - An internal saturating counter (max 255) of items dropped in the current crossing, cleared at init.
    - Its value is latched to drop_count alongside item_count at t+1.
    - Reset value is 0.
  - Without the macro: the port and counter do not exist; overflow alone signals loss.

Test Plan:
- Reset, then din_valid pulses with no init -> wr_en stays 0, count_valid=0, rd_page=1.
- init, 5 items D0..D4 in consecutive cycles, init -> writes to addr 0x00..0x04 one cycle after each item; after the second init: item_count=5, rd_page=0, count_valid=1, overflow=0, next writes go to 0x40+.
- Fill 70 items in one crossing, then init -> addresses 0x00..0x3E written (63 writes); item_count=63, overflow=1. With PRIO_WR_DROP_CNT_EN: drop_count=7.
- Item 3 of a crossing coincident with init, after items 0..2 -> item_count=3; the coincident item is written at {new page,0}; the following init reports item_count=1.
- Three consecutive init strobes with no data -> item_count=0 each time, rd_page toggles 0,1,0, overflow=0.
- reset asserted mid-crossing after 10 items, coincident with din_valid -> the next cycle has wr_en=0 and all outputs at reset values; the next init starts page 0 at addr 0.
